// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU: opcodes and controller phases.
// Used by the controller and the ALU so both agree on the instruction set.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    localparam int unsigned WDOG_W = 8;

    // Opcodes that read an operand from memory and write the accumulator.
    function automatic logic is_aluop(input opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/ctrl_wdog.sv
// Memory-wait watchdog: counts stalled cycles and flags the one that reaches LIMIT.
module ctrl_wdog
    import cpu_pkg::*;
#(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LAST_CNT = WDOG_W'(LIMIT - 1);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count enabled cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {WDOG_W{1'b0}};
        end else if (en) begin
            cnt_d = cnt_q + {{(WDOG_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {WDOG_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current stalled cycle is the LIMIT-th one.
    assign expired = en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer with memory-wait stall, halt/restart and
// sticky memory-timeout error. Controls are a Moore decode of the phase register.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_rdy,
    input  logic       go,
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       wr,
    output logic       data_e,
    output logic       halt,
    output logic       err,
    output logic [2:0] phase
);

    phase_e  phase_q, phase_d;
    logic    halted_q, halted_d;
    logic    err_q, err_d;
    opcode_e op_s;
    logic    alu_s;
    logic    stall_s;
    logic    wdog_clr_s;
    logic    expired_s;

    assign op_s       = opcode_e'(opcode);
    assign alu_s      = is_aluop(op_s);
    assign stall_s    = !halted_q && !mem_rdy &&
                        ((phase_q == PH_INST_FETCH) || ((phase_q == PH_OP_FETCH) && alu_s));
    // Any non-stalled cycle clears, so the count is zero on entry to each fetch.
    assign wdog_clr_s = !stall_s;

    ctrl_wdog #(.LIMIT(MEM_TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wdog_clr_s),
        .en      (stall_s),
        .expired (expired_s)
    );

    // Next phase / halt / error; timeout outranks any phase advance.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        err_d    = err_q;
        if (halted_q) begin
            if (go) begin
                halted_d = 1'b0;
                phase_d  = PH_INST_ADDR;
            end else begin
                phase_d  = phase_q;
            end
        end else if (expired_s) begin
            err_d    = 1'b1;
            halted_d = 1'b1;
            phase_d  = PH_OP_ADDR;
        end else if (stall_s) begin
            phase_d  = phase_q;
        end else if ((phase_q == PH_OP_ADDR) && (op_s == OP_HLT)) begin
            halted_d = 1'b1;
        end else begin
            phase_d  = phase_e'(phase_q + 3'd1);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // Control decode; a stalled fetch keeps only the address select and read.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        data_e = 1'b0;
        if (halted_q) begin
            sel = 1'b0;
        end else begin
            case (phase_q)
                PH_INST_ADDR:  sel = 1'b1;
                PH_INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
                PH_INST_LOAD,
                PH_IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
                PH_OP_ADDR:    inc_pc = 1'b1;
                PH_OP_FETCH:   rd = alu_s;
                PH_ALU_OP: begin
                    rd     = alu_s;
                    inc_pc = (op_s == OP_SKZ) && zero;
                    ld_pc  = (op_s == OP_JMP);
                    data_e = (op_s == OP_STO);
                end
                PH_STORE: begin
                    rd     = alu_s;
                    ld_pc  = (op_s == OP_JMP);
                    ld_ac  = alu_s;
                    wr     = (op_s == OP_STO);
                    data_e = (op_s == OP_STO);
                end
                default:       sel = 1'b0;
            endcase
            if (stall_s) begin
                ld_ir  = 1'b0;
                inc_pc = 1'b0;
                ld_pc  = 1'b0;
                ld_ac  = 1'b0;
                wr     = 1'b0;
                data_e = 1'b0;
            end else begin
                ld_ir  = ld_ir;
            end
        end
    end

    assign halt  = halted_q;
    assign err   = err_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed, scoreboarded check of cpu_controller phase sequencing and control decode.
module tb_cpu_controller;
    import cpu_pkg::*;

    typedef logic [12:0] vec_t;   // {halt, err, phase[2:0], sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e}

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero, mem_rdy, go;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, err;
    logic [2:0] phase;

    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic exp_err = 1'b0;

    cpu_controller #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_rdy(mem_rdy), .go(go),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc), .ld_ac(ld_ac),
        .wr(wr), .data_e(data_e), .halt(halt), .err(err), .phase(phase)
    );

    always #5 clk = ~clk;

    // Expected outputs from the phase table for a running (non-halted) controller.
    function automatic vec_t dec(input int ph, input logic [2:0] op, input logic z, input logic stall);
        logic alu, s, r, li, ip, lp, la, w, de;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        s   = (ph <= 3);
        r   = ((ph >= 1) && (ph <= 3)) || ((ph >= 5) && alu);
        li  = (ph == 2) || (ph == 3);
        ip  = (ph == 4) || ((ph == 6) && (op == 3'd1) && z);
        lp  = ((ph == 6) || (ph == 7)) && (op == 3'd7);
        la  = (ph == 7) && alu;
        w   = (ph == 7) && (op == 3'd6);
        de  = ((ph == 6) || (ph == 7)) && (op == 3'd6);
        if (stall) begin
            li = 1'b0; ip = 1'b0; lp = 1'b0; la = 1'b0; w = 1'b0; de = 1'b0;
        end
        return {1'b0, exp_err, 3'(ph), s, r, li, ip, lp, la, w, de};
    endfunction

    function automatic vec_t halted_vec();
        return {1'b1, exp_err, 3'd4, 8'b0};
    endfunction

    task automatic check_now(input string tag, input logic [2:0] op, input logic z,
                             input logic rdy, input logic g, input vec_t e);
        vec_t obs, want;
        opcode = op; zero = z; mem_rdy = rdy; go = g;
        exp_q.push_back(e);
        #1;
        obs  = {halt, err, phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e};
        want = exp_q.pop_front();
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
    endtask

    task automatic apply(input string tag, input logic [2:0] op, input logic z,
                         input logic rdy, input logic g, input vec_t e);
        check_now(tag, op, z, rdy, g, e);
        @(negedge clk);
    endtask

    task automatic run_phases(input logic [2:0] op, input logic z, input int from, input int to,
                              input logic rdy);
        for (int p = from; p <= to; p++)
            apply($sformatf("op%0d_z%0d_ph%0d", op, z, p), op, z, rdy, 1'b0, dec(p, op, z, 1'b0));
    endtask

    initial begin
        rst_n = 1'b0; opcode = 3'd0; zero = 1'b0; mem_rdy = 1'b1; go = 1'b0;
        #2;
        check_now("reset", 3'd0, 1'b0, 1'b1, 1'b0, dec(0, 3'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        run_phases(3'd2, 1'b0, 0, 7, 1'b1);          // ADD
        run_phases(3'd1, 1'b1, 0, 7, 1'b1);          // SKZ taken
        run_phases(3'd1, 1'b0, 0, 7, 1'b1);          // SKZ not taken
        run_phases(3'd6, 1'b0, 0, 4, 1'b1);          // STO, operand fetch does not wait
        run_phases(3'd6, 1'b0, 5, 7, 1'b0);
        run_phases(3'd7, 1'b1, 0, 7, 1'b1);          // JMP
        run_phases(3'd3, 1'b1, 0, 7, 1'b1);          // AND

        // Short stalls in both fetch phases recover without error.
        run_phases(3'd4, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++)
            apply("ifetch_stall", 3'd4, 1'b0, 1'b0, 1'b0, dec(1, 3'd4, 1'b0, 1'b1));
        run_phases(3'd4, 1'b0, 1, 4, 1'b1);
        for (int i = 0; i < 2; i++)
            apply("ofetch_stall", 3'd4, 1'b0, 1'b0, 1'b0, dec(5, 3'd4, 1'b0, 1'b1));
        run_phases(3'd4, 1'b0, 5, 7, 1'b1);

        // HLT, then restart with go; go while running is ignored.
        run_phases(3'd0, 1'b0, 0, 4, 1'b1);
        apply("hlt_hold0", 3'd0, 1'b0, 1'b1, 1'b0, halted_vec());
        apply("hlt_hold1", 3'd0, 1'b0, 1'b1, 1'b0, halted_vec());
        apply("hlt_go", 3'd0, 1'b0, 1'b1, 1'b1, halted_vec());
        apply("hlt_restart", 3'd2, 1'b0, 1'b1, 1'b1, dec(0, 3'd2, 1'b0, 1'b0));
        run_phases(3'd2, 1'b0, 1, 7, 1'b1);

        // Instruction fetch never completes: timeout after exactly 15 stalled cycles.
        run_phases(3'd2, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 15; i++)
            apply($sformatf("tmo_stall%0d", i), 3'd2, 1'b0, 1'b0, 1'b0, dec(1, 3'd2, 1'b0, 1'b1));
        exp_err = 1'b1;
        apply("tmo_halted", 3'd2, 1'b0, 1'b1, 1'b0, halted_vec());
        apply("tmo_go", 3'd2, 1'b0, 1'b1, 1'b1, halted_vec());
        apply("tmo_restart", 3'd5, 1'b0, 1'b1, 1'b0, dec(0, 3'd5, 1'b0, 1'b0));

        // Asynchronous reset in the middle of LDA's ALU_OP.
        run_phases(3'd5, 1'b0, 1, 5, 1'b1);
        check_now("lda_aluop", 3'd5, 1'b0, 1'b1, 1'b0, dec(6, 3'd5, 1'b0, 1'b0));
        rst_n = 1'b0;
        exp_err = 1'b0;
        check_now("async_rst", 3'd5, 1'b0, 1'b1, 1'b0, dec(0, 3'd5, 1'b0, 1'b0));
        @(negedge clk);
        check_now("rst_held", 3'd5, 1'b0, 1'b1, 1'b0, dec(0, 3'd5, 1'b0, 1'b0));
        rst_n = 1'b1;
        @(negedge clk);
        run_phases(3'd5, 1'b0, 1, 7, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 15, maximum wait cycles for mem_rdy in a fetch phase (1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; reset is asynchronous and active-low.
REQ-004 Port: opcode  input  3  instruction opcode from instruction register; valid from INST_LOAD onward.
REQ-005 Port: zero  input  1  accumulator-is-zero flag from ALU (a_is_zero).
REQ-006 Port: mem_rdy  input  1  memory read data valid.
REQ-007 Port: go  input  1  restart request; honoured only while halted.
REQ-008 Ports: sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e  output  1 each  datapath controls: address mux to PC, memory read, IR load, PC increment, PC load, accumulator load, memory write, data bus drive.
REQ-009 Port: halt  output  1  processor halted.
REQ-010 Port: err  output  1  sticky memory-timeout flag.
REQ-011 Port: phase  output  3  current phase, for debug.

Function
REQ-012 Opcode encoding SHALL be HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111; ALUOP = ADD|AND|XOR|LDA.
REQ-013 Phase sequence SHALL be INST_ADDR(0) -> INST_FETCH(1) -> INST_LOAD(2) -> IDLE(3) -> OP_ADDR(4) -> OP_FETCH(5) -> ALU_OP(6) -> STORE(7) -> INST_ADDR, one phase per cycle except where stalled or halted.
REQ-014 INST_FETCH SHALL hold until mem_rdy=1; OP_FETCH SHALL hold until mem_rdy=1 only when opcode is ALUOP, otherwise advance unconditionally.
REQ-015 Wait counter SHALL clear on entering a fetch phase and increment each stalled cycle; reaching MEM_TIMEOUT SHALL set err and enter halted state.
REQ-016 In OP_ADDR with opcode HLT, the next state SHALL be halted; halted holds phase at OP_ADDR with all controls 0 except halt=1.
REQ-017 In halted state, go=1 SHALL clear halt and move to INST_ADDR next cycle; go SHALL NOT clear err; go outside halted is ignored.
REQ-018 Outputs SHALL be combinational decode of registered state, opcode and zero (Moore w.r.t. phase), with no extra latency:
  - sel: phases 0-3.
  - rd: phases 1-3; phases 5-7 if ALUOP.
  - ld_ir: phases 2-3.
  - inc_pc: phase 4 (not halted); phase 6 if SKZ and zero=1.
  - ld_pc: phases 6-7 if JMP.
  - ld_ac: phase 7 if ALUOP.
  - wr: phase 7 if STO.
  - data_e: phases 6-7 if STO.
REQ-019 ld_pc and inc_pc SHALL never be asserted together; wr and rd SHALL never be asserted together.
REQ-020 Decoded controls SHALL be suppressed (0) during a stalled fetch except rd and sel, which stay asserted.
REQ-021 err and halt asserting in the same cycle (timeout) SHALL take priority over any pending phase advance.

Reset
REQ-022 On rst_n=0, asynchronously: phase=INST_ADDR, halted=0, err=0, wait counter=0; hence sel=1, all other control outputs 0, phase=0.
REQ-023 Reset mid-instruction SHALL abandon the instruction; first cycle after release is INST_ADDR.

Structure
REQ-024 Opcode constants and the phase encoding SHALL live in shared package cpu_pkg, also used by the ALU.
REQ-025 Timeout counter SHALL be one sub-module, ctrl_wdog (clear, enable, limit parameter, expired output).

Verification
REQ-026 Reset released, mem_rdy=1, opcode=ADD -> phases 0..7 in 8 cycles; ld_ac=1 only in phase 7; rd=1 in 1,2,3,5,6,7.
REQ-027 opcode=SKZ, zero=1 -> inc_pc high in phases 4 and 6; with zero=0 -> inc_pc only in phase 4.
REQ-028 opcode=STO -> data_e high in phases 6-7, wr high in phase 7 only, rd low in 5-7; opcode=JMP -> ld_pc in 6-7, inc_pc only in 4.
REQ-029 opcode=HLT -> halt=1 from the cycle after OP_ADDR, phase frozen at 4; go pulse -> phase 0 next cycle, halt=0.
REQ-030 mem_rdy held 0 in INST_FETCH, MEM_TIMEOUT=15 -> after 15 stalled cycles err=1, halt=1; go restarts but err stays 1 until rst_n=0.
REQ-031 rst_n asserted during ALU_OP of LDA -> outputs immediately sel=1, others 0, phase=0 without clock edge.
